axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Read-side AXI3 master for the core. It arbitrates instruction-cache and data-cache read requests onto the single AR/R channel pair that the core exports. It keeps exactly one read transaction outstanding and routes the returned beats back to the requester that issued it. It sits directly upstream of the core's top-level AXI read ports; the write channels are driven by a separate block.

## Interface
- LINE_WORDS, 4, words per cache-line burst (power of two, 2..16)
- DC_ID, 1, arid value for dcache reads; icache reads use arid 0
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- ic_req  in  1  icache line-read request
- ic_addr  in  32  icache request address
- ic_rdy  out  1  icache request accepted this cycle when ic_req && ic_rdy
- ic_ret_valid  out  1  icache return beat valid
- ic_ret_last  out  1  final beat of icache burst
- ic_ret_data  out  32  icache return data
- dc_req  in  1  dcache read request
- dc_type  in  3  0 byte, 1 half, 2 word, 4 line
- dc_addr  in  32  dcache request address
- dc_rdy  out  1  dcache request accepted when dc_req && dc_rdy
- dc_ret_valid  out  1  dcache return beat valid
- dc_ret_last  out  1  final beat of dcache return
- dc_ret_data  out  32  dcache return data
- arid  out  4  read id
- araddr  out  32  read address
- arlen  out  8  beats minus one
- arsize  out  3  bytes per beat, log2
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  address valid
- arready  in  1  address accepted
- rdata  in  32  read data
- rlast  in  1  last beat
- rvalid  in  1  data valid
- rready  out  1  data accepted

## Operation
- FSM states: IDLE, AR, DATA. Reset state is IDLE.
- IDLE:
  - dc_rdy = 1.
  - ic_rdy = !dc_req. The dcache has fixed priority.
  - On an accepted request, register arid, araddr, arlen, arsize and owner; go to AR.
- Dcache request field mapping:
  - Line read (type 4): arsize 2, arlen LINE_WORDS-1, araddr low log2(LINE_WORDS*4) bits forced to 0.
  - Type 0/1/2: arsize = type[1:0], arlen 0, araddr passed unmodified.
  - Types 3, 5, 6, 7 are treated as type 2.
- Icache requests are always line reads with the same forced alignment, arid 0.
- AR: arvalid = 1, with all AR fields stable. On arready go to DATA.
- DATA: rready = 1. A beat is taken when rvalid && rready. Routing:
  - Owner icache: ic_ret_valid=1, ic_ret_data=rdata, ic_ret_last=rlast.
  - Owner dcache: the dc_ret_* outputs, likewise.
  - The non-owner's ret_valid stays 0.
- DATA exit: a beat with rlast returns the FSM to IDLE.
- rid and rresp are not consumed. Only one transaction is ever outstanding, so ordering is implicit.
- Reset values: all *_rdy 0 while aresetn is low. arvalid, rready and all *_ret_valid/last are 0. arid, araddr, arlen, arsize are 0. arburst is always 2'b01.

## Timing
- An accepted request in cycle N gives arvalid=1 in cycle N+1 (registered).
- arvalid holds with constant fields until the arready cycle. The FSM is in DATA from the next cycle.
- Return beats pass combinationally from rdata/rvalid/rlast to the owner's ret outputs in the same cycle. There is no buffering; the requester must always sink beats.
- The cycle after the rlast beat is IDLE. A new request may be accepted there, so minimum back-to-back spacing is request, AR, one data beat, IDLE.
- Simultaneous ic_req and dc_req in IDLE: dcache is granted; ic_rdy=0 that cycle; icache is granted in the next IDLE cycle if dc_req is low.
- rvalid while in IDLE or AR is ignored (rready=0).
- Asynchronous reset mid-transaction:
  - FSM goes to IDLE immediately; arvalid, rready and ret outputs drop without waiting for a clock.
  - The outstanding transaction is abandoned; the slave is reset by the same system reset.
- Reset deassertion: first IDLE cycle is the first rising edge after aresetn goes high; dc_rdy=1 from then.

## Test plan
- Icache line read at 0x1C00_0014, LINE_WORDS=4 -> araddr 0x1C00_0010, arlen 3, arsize 2, arid 0; four beats on ic_ret with ic_ret_last on beat 4; dc_ret_valid stays 0.
- Dcache byte read, type 0 at 0xBFAF_8003 -> araddr 0xBFAF_8003, arlen 0, arsize 0, arid 1; single dc_ret beat with dc_ret_last=1.
- ic_req and dc_req high in the same IDLE cycle -> dcache transaction first (arid 1), icache AR issued only after the dcache rlast beat.
- arready held low 5 cycles -> arvalid stays high with constant araddr/arlen for all 5 cycles; no ret beats occur.
- rvalid gaps: rvalid toggles 1,0,0,1,0,1,1 on a 4-beat line -> exactly four ret_valid pulses, data in order, last on fourth.
- aresetn low during the second data beat -> rready, ret_valid and arvalid go to 0 asynchronously; after release a new dcache word read completes normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Read-side AXI3 master: arbitrates icache/dcache read requests onto one AR/R pair,
// one transaction outstanding, with return beats routed combinationally to the owner.
module axi_rd_arbiter #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned DC_ID      = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_rdy,
    output logic        ic_ret_valid,
    output logic        ic_ret_last,
    output logic [31:0] ic_ret_data,
    input  logic        dc_req,
    input  logic [2:0]  dc_type,
    input  logic [31:0] dc_addr,
    output logic        dc_rdy,
    output logic        dc_ret_valid,
    output logic        dc_ret_last,
    output logic [31:0] dc_ret_data,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [31:0] LineMask = ~(32'(LINE_WORDS * 4) - 32'd1);
    localparam logic [7:0]  LineLen  = 8'(LINE_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StAr, StData} state_e;

    state_e      state_q, state_d;
    logic        rdy_en_q;
    logic        owner_dc_q, owner_dc_d;
    logic [3:0]  arid_q, arid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q, arsize_d;
    logic        beat;

    // rdy_en_q holds the request ports off until the first edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            rdy_en_q   <= 1'b0;
            owner_dc_q <= 1'b0;
            arid_q     <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
        end else begin
            state_q    <= state_d;
            rdy_en_q   <= 1'b1;
            owner_dc_q <= owner_dc_d;
            arid_q     <= arid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_dc_d = owner_dc_q;
        arid_d     = arid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        ic_rdy     = 1'b0;
        dc_rdy     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        unique case (state_q)
            StIdle: begin
                dc_rdy = rdy_en_q;
                ic_rdy = rdy_en_q & ~dc_req;
                if (rdy_en_q && dc_req) begin
                    owner_dc_d = 1'b1;
                    arid_d     = 4'(DC_ID);
                    state_d    = StAr;
                    if (dc_type == 3'd4) begin
                        araddr_d = dc_addr & LineMask;
                        arlen_d  = LineLen;
                        arsize_d = 3'd2;
                    end else begin
                        araddr_d = dc_addr;
                        arlen_d  = 8'd0;
                        // Undefined types (3, 5, 6, 7) fall back to a word read.
                        arsize_d = (dc_type[2] || (&dc_type[1:0])) ? 3'd2
                                                                   : {1'b0, dc_type[1:0]};
                    end
                end else if (rdy_en_q && ic_req) begin
                    owner_dc_d = 1'b0;
                    arid_d     = 4'd0;
                    araddr_d   = ic_addr & LineMask;
                    arlen_d    = LineLen;
                    arsize_d   = 3'd2;
                    state_d    = StAr;
                end
            end
            StAr: begin
                arvalid = 1'b1;
                if (arready) state_d = StData;
            end
            StData: begin
                rready = 1'b1;
                if (rvalid && rlast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign beat         = (state_q == StData) && rvalid;
    assign ic_ret_valid = beat && !owner_dc_q;
    assign ic_ret_last  = ic_ret_valid && rlast;
    assign ic_ret_data  = rdata;
    assign dc_ret_valid = beat && owner_dc_q;
    assign dc_ret_last  = dc_ret_valid && rlast;
    assign dc_ret_data  = rdata;

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = arsize_q;
    assign arburst = 2'b01;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter (LINE_WORDS=4, DC_ID=1).
module tb_axi_rd_arbiter;

    logic        aclk, aresetn;
    logic        ic_req, ic_rdy, ic_ret_valid, ic_ret_last;
    logic [31:0] ic_addr, ic_ret_data;
    logic        dc_req, dc_rdy, dc_ret_valid, dc_ret_last;
    logic [2:0]  dc_type;
    logic [31:0] dc_addr, dc_ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] rdata;

    int checks = 0;
    int failures = 0;

    axi_rd_arbiter #(.LINE_WORDS(4), .DC_ID(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdy(ic_rdy),
        .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
        .dc_req(dc_req), .dc_type(dc_type), .dc_addr(dc_addr), .dc_rdy(dc_rdy),
        .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic req_ic(input logic [31:0] addr);
        ic_req  = 1'b1;
        ic_addr = addr;
        @(negedge aclk);
        chk("ic_rdy", 32'(ic_rdy), 32'd1);
        next_cycle();
        ic_req = 1'b0;
    endtask

    task automatic req_dc(input logic [2:0] typ, input logic [31:0] addr);
        dc_req  = 1'b1;
        dc_type = typ;
        dc_addr = addr;
        @(negedge aclk);
        chk("dc_rdy", 32'(dc_rdy), 32'd1);
        next_cycle();
        dc_req = 1'b0;
    endtask

    // Holds arready low for stall cycles, with rvalid noise that must be ignored.
    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input int stall);
        for (int k = 0; k <= stall; k++) begin
            rvalid = (stall != 0);
            @(negedge aclk);
            chk("arvalid", 32'(arvalid), 32'd1);
            chk("arid", 32'(arid), 32'(id));
            chk("araddr", araddr, addr);
            chk("arlen", 32'(arlen), 32'(len));
            chk("arsize", 32'(arsize), 32'(size));
            chk("ar_rready", 32'(rready), 32'd0);
            chk("ar_retv", 32'({ic_ret_valid, dc_ret_valid}), 32'd0);
            arready = (k == stall);
            rvalid  = 1'b0;
            next_cycle();
        end
        arready = 1'b0;
    endtask

    task automatic beat(input logic to_dc, input logic [31:0] data, input logic last);
        rvalid = 1'b1;
        rdata  = data;
        rlast  = last;
        @(negedge aclk);
        chk("rready", 32'(rready), 32'd1);
        chk("owner_valid", 32'(to_dc ? dc_ret_valid : ic_ret_valid), 32'd1);
        chk("other_valid", 32'(to_dc ? ic_ret_valid : dc_ret_valid), 32'd0);
        chk("ret_data", to_dc ? dc_ret_data : ic_ret_data, data);
        chk("ret_last", 32'(to_dc ? dc_ret_last : ic_ret_last), 32'(last));
        next_cycle();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic gap();
        rvalid = 1'b0;
        @(negedge aclk);
        chk("gap_rready", 32'(rready), 32'd1);
        chk("gap_retv", 32'({ic_ret_valid, dc_ret_valid}), 32'd0);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_type = '0;
        dc_addr = '0; arready = 1'b0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
        #12;
        chk("rst_dc_rdy", 32'(dc_rdy), 32'd0);
        chk("rst_ic_rdy", 32'(ic_rdy), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_arlen", 32'(arlen), 32'd0);
        chk("arburst", 32'(arburst), 32'd1);
        #10;
        aresetn = 1'b1;
        #1;
        chk("rel_dc_rdy_pre_edge", 32'(dc_rdy), 32'd0);
        next_cycle();
        chk("rel_dc_rdy", 32'(dc_rdy), 32'd1);

        // Icache line read, address aligned down to 16 bytes.
        req_ic(32'h1C00_0014);
        do_ar(4'd0, 32'h1C00_0010, 8'd3, 3'd2, 0);
        for (int i = 0; i < 4; i++) beat(1'b0, 32'hA000_0000 + 32'(i), i == 3);
        @(negedge aclk);
        chk("idle_after_ic", 32'(dc_rdy), 32'd1);
        next_cycle();

        // Dcache byte read, unaligned address passes through.
        req_dc(3'd0, 32'hBFAF_8003);
        do_ar(4'd1, 32'hBFAF_8003, 8'd0, 3'd0, 0);
        beat(1'b1, 32'h1122_3344, 1'b1);

        // Dcache line, half and undefined-type reads.
        req_dc(3'd4, 32'h0000_123C);
        do_ar(4'd1, 32'h0000_1230, 8'd3, 3'd2, 0);
        beat(1'b1, 32'h5555_0001, 1'b1);
        req_dc(3'd1, 32'h0000_0102);
        do_ar(4'd1, 32'h0000_0102, 8'd0, 3'd1, 0);
        beat(1'b1, 32'h5555_0002, 1'b1);
        req_dc(3'd6, 32'h0000_0201);
        do_ar(4'd1, 32'h0000_0201, 8'd0, 3'd2, 0);
        beat(1'b1, 32'h5555_0003, 1'b1);

        // Simultaneous requests: dcache first, icache after its rlast.
        ic_req = 1'b1; ic_addr = 32'h2000_0008;
        dc_req = 1'b1; dc_type = 3'd2; dc_addr = 32'h1000_0004;
        @(negedge aclk);
        chk("both_dc_rdy", 32'(dc_rdy), 32'd1);
        chk("both_ic_rdy", 32'(ic_rdy), 32'd0);
        next_cycle();
        dc_req = 1'b0;
        @(negedge aclk);
        chk("ar_ic_rdy", 32'(ic_rdy), 32'd0);
        do_ar(4'd1, 32'h1000_0004, 8'd0, 3'd2, 0);
        beat(1'b1, 32'hDDDD_0000, 1'b1);
        req_ic(32'h2000_0008);
        // arready held low five cycles, then gapped beats 1,0,0,1,0,1,1.
        do_ar(4'd0, 32'h2000_0000, 8'd3, 3'd2, 5);
        beat(1'b0, 32'hC000_0000, 1'b0);
        gap();
        gap();
        beat(1'b0, 32'hC000_0001, 1'b0);
        gap();
        beat(1'b0, 32'hC000_0002, 1'b0);
        beat(1'b0, 32'hC000_0003, 1'b1);

        // Asynchronous reset during the second beat.
        req_dc(3'd4, 32'h3000_0000);
        do_ar(4'd1, 32'h3000_0000, 8'd3, 3'd2, 0);
        beat(1'b1, 32'hEEEE_0000, 1'b0);
        rvalid = 1'b1; rdata = 32'hEEEE_0001;
        @(negedge aclk);
        chk("pre_rst_valid", 32'(dc_ret_valid), 32'd1);
        #1 aresetn = 1'b0;
        #1;
        chk("arst_rready", 32'(rready), 32'd0);
        chk("arst_ret_valid", 32'(dc_ret_valid), 32'd0);
        chk("arst_arvalid", 32'(arvalid), 32'd0);
        chk("arst_dc_rdy", 32'(dc_rdy), 32'd0);
        @(posedge aclk);
        #2 aresetn = 1'b1;
        rvalid = 1'b0;
        next_cycle();
        req_dc(3'd2, 32'h3000_0008);
        do_ar(4'd1, 32'h3000_0008, 8'd0, 3'd2, 0);
        beat(1'b1, 32'h7777_8888, 1'b1);
        @(negedge aclk);
        chk("final_arvalid", 32'(arvalid), 32'd0);
        chk("final_ic_rdy", 32'(ic_rdy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
